// File: rtl/dbus_mem_responder_pkg.sv
// Shared types and constants for the dbus memory responder.
// Optional stall injection is enabled by defining DBUS_RESP_STALL_EN.
package dbus_mem_responder_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned STRB_W = WORD_W / 8;
   localparam int unsigned LFSR_W = 16;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic              valid;
      logic [31:0]       addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [WORD_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [WORD_W-1:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } resp_state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/dbus_sram_array.sv
// Word-addressed RAM: one registered read port, one byte-strobed write port.
// A same-cycle read and write to one word returns the old contents.
module dbus_sram_array
   import dbus_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   input  logic [STRB_W-1:0] wr_strobe,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (wr_strobe[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus target: accepts one request at a time, responds LATENCY cycles later.
// Define DBUS_RESP_STALL_EN to add LFSR-driven accept and response stalls.
module dbus_mem_responder
   import dbus_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

   resp_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] idx_q;
   logic [STRB_W-1:0] strobe_q;
   logic [WORD_W-1:0] wdata_q;
   logic              data_ok_q;

   logic              addr_ok_c;
   logic              stall_c;
   logic [1:0]        extra_c;
   logic [ADDR_W-1:0] rd_idx_c;
   logic [STRB_W-1:0] wr_strobe_c;
   logic [WORD_W-1:0] rd_data;
   logic              unused_c;

   assign unused_c = ^{dreq.size, dreq.addr[31:ADDR_W+2], dreq.addr[1:0]};

`ifdef DBUS_RESP_STALL_EN
   logic [LFSR_W-1:0] lfsr;
   logic              stalled_q;
   logic              exit_c;

   // Point where the request would otherwise enter RESP.
   assign exit_c  = ((state == IDLE) && addr_ok_c && (LATENCY == 1)) ||
                    ((state == BUSY) && (cnt == '0));
   assign extra_c = lfsr[2:1];
   assign stall_c = !stalled_q && (extra_c != 2'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr      <= LFSR_SEED;
         stalled_q <= 1'b0;
      end else begin
         lfsr <= lfsr_next(lfsr);
         if (state == RESP) begin
            stalled_q <= 1'b0;
         end else if (exit_c && stall_c) begin
            stalled_q <= 1'b1;
         end
      end
   end

   assign addr_ok_c = resetn && (state == IDLE) && dreq.valid && !lfsr[0];
`else
   assign extra_c   = 2'd0;
   assign stall_c   = 1'b0;
   assign addr_ok_c = resetn && (state == IDLE) && dreq.valid;
`endif

   // Reading the live address in IDLE lets LATENCY==1 respond on the next cycle.
   assign rd_idx_c    = (state == IDLE) ? dreq.addr[ADDR_W+1:2] : idx_q;
   assign wr_strobe_c = (state == RESP) ? strobe_q : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         idx_q     <= '0;
         strobe_q  <= '0;
         wdata_q   <= '0;
         data_ok_q <= 1'b0;
      end else begin
         data_ok_q <= 1'b0;
         case (state)
            IDLE: begin
               if (addr_ok_c) begin
                  idx_q    <= dreq.addr[ADDR_W+1:2];
                  strobe_q <= dreq.strobe;
                  wdata_q  <= dreq.data;
                  if (LATENCY == 1) begin
                     if (stall_c) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(extra_c) - CNT_W'(1);
                     end else begin
                        state     <= RESP;
                        data_ok_q <= 1'b1;
                     end
                  end else begin
                     state <= BUSY;
                     cnt   <= BUSY_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (stall_c) begin
                  cnt <= CNT_W'(extra_c) - CNT_W'(1);
               end else begin
                  state     <= RESP;
                  data_ok_q <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   dbus_sram_array #(
      .ADDR_W (ADDR_W)
   ) u_sram (
      .clk       (clk),
      .rd_en     (1'b1),
      .rd_addr   (rd_idx_c),
      .rd_data   (rd_data),
      .wr_strobe (wr_strobe_c),
      .wr_addr   (idx_q),
      .wr_data   (wdata_q)
   );

   always_comb begin
      dresp         = '0;
      dresp.addr_ok = addr_ok_c;
      dresp.data_ok = data_ok_q;
      dresp.data    = data_ok_q ? rd_data : '0;
   end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench for dbus_mem_responder: LATENCY=2 instance for data paths,
// LATENCY=1 instance for back-to-back acceptance.
module tb_dbus_mem_responder;
   import dbus_mem_responder_pkg::*;

   localparam int LAT_A = 2;
   localparam int LAT_B = 1;
`ifdef DBUS_RESP_STALL_EN
   localparam int EXTRA     = 3;
   localparam int GAP_SLACK = 64;
`else
   localparam int EXTRA     = 0;
   localparam int GAP_SLACK = 0;
`endif

   typedef struct {
      logic        chk;
      logic [31:0] data;
      int          acc;
   } exp_t;

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   dbus_req_t  dreq_a, dreq_b;
   dbus_resp_t dresp_a, dresp_b;
   exp_t       q_a[$];
   exp_t       q_b[$];
   int         cyc   = 0;
   int         tests = 0;
   int         fails = 0;
   logic [31:0] mdl [16];
   logic [31:0] b_addr [4];
   logic [3:0]  b_strb [4];
   logic [31:0] b_data [4];
   logic        b_chk  [4];
   logic [31:0] b_exp  [4];

   dbus_mem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .resetn(resetn), .dreq(dreq_a), .dresp(dresp_a));
   dbus_mem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .resetn(resetn), .dreq(dreq_b), .dresp(dresp_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the LATENCY=2 instance.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (resetn) begin
         if (dresp_a.data_ok) begin
            chk("a_addr_ok_in_resp", 32'(dresp_a.addr_ok), 32'd0);
            if (q_a.size() == 0) begin
               chk("a_spurious_data_ok", 32'(q_a.size()), 32'd1);
            end else begin
               e   = q_a.pop_front();
               lat = cyc - e.acc;
               if (e.chk) chk("a_data", dresp_a.data, e.data);
               chk("a_latency", 32'(lat),
                   (lat >= LAT_A && lat <= LAT_A + EXTRA) ? 32'(lat) : 32'(LAT_A));
            end
         end else begin
            chk("a_data_zero_when_idle", dresp_a.data, 32'd0);
         end
      end
   end

   // Monitor for the LATENCY=1 instance.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (resetn) begin
         if (dresp_b.data_ok) begin
            chk("b_addr_ok_in_resp", 32'(dresp_b.addr_ok), 32'd0);
            if (q_b.size() == 0) begin
               chk("b_spurious_data_ok", 32'(q_b.size()), 32'd1);
            end else begin
               e   = q_b.pop_front();
               lat = cyc - e.acc;
               if (e.chk) chk("b_data", dresp_b.data, e.data);
               chk("b_latency", 32'(lat),
                   (lat >= LAT_B && lat <= LAT_B + EXTRA) ? 32'(lat) : 32'(LAT_B));
            end
         end else begin
            chk("b_data_zero_when_idle", dresp_b.data, 32'd0);
         end
      end
   end

   // Issue one request on instance A; after acceptance the bus fields are scrambled.
   task automatic req_a(input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic ck, input logic [31:0] exp);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      dreq_a.valid  = 1'b1;
      dreq_a.addr   = addr;
      dreq_a.size   = (strb == 4'hF) ? MSIZE4 : MSIZE1;
      dreq_a.strobe = strb;
      dreq_a.data   = wd;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (dresp_a.addr_ok) begin
            got = 1'b1;
            break;
         end
      end
      chk("a_accept", 32'(got), 32'd1);
      if (got) q_a.push_back('{ck, exp, cyc});
      @(posedge clk); #1;
      dreq_a.valid  = 1'b0;
      dreq_a.addr   = addr + 32'd4;
      dreq_a.strobe = 4'hF;
      dreq_a.data   = ~wd;
   endtask

   initial begin
      logic        got;
      int          idx, last, gap;
      logic [3:0]  strb;
      logic [31:0] wd;

      dreq_a = '0;
      dreq_b = '0;
      dreq_a.valid = 1'b1;
      dreq_b.valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_a_addr_ok", 32'(dresp_a.addr_ok), 32'd0);
      chk("rst_a_data_ok", 32'(dresp_a.data_ok), 32'd0);
      chk("rst_a_data",    dresp_a.data,         32'd0);
      chk("rst_b_addr_ok", 32'(dresp_b.addr_ok), 32'd0);
      chk("rst_b_data_ok", 32'(dresp_b.data_ok), 32'd0);
      chk("rst_b_data",    dresp_b.data,         32'd0);
      dreq_a.valid = 1'b0;
      dreq_b.valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      // Full-word write/read, byte write over an existing word, wrap and low bits.
      req_a(32'h0000_0100, 4'hF,    32'hDEADBEEF, 1'b0, 32'h0);
      req_a(32'h0000_0100, 4'h0,    32'h0,        1'b1, 32'hDEADBEEF);
      req_a(32'h0000_0102, 4'b0100, 32'h00AB0000, 1'b1, 32'hDEADBEEF);
      req_a(32'h0000_0100, 4'h0,    32'h0,        1'b1, 32'hDEABBEEF);
      req_a(32'h0000_0000, 4'hF,    32'h11111111, 1'b0, 32'h0);
      req_a(32'h0000_1000, 4'h0,    32'h0,        1'b1, 32'h11111111);
      req_a(32'h0000_0003, 4'h0,    32'h0,        1'b1, 32'h11111111);
      req_a(32'h0000_0002, 4'b0011, 32'h00002222, 1'b1, 32'h11111111);
      req_a(32'hFFFF_F000, 4'h0,    32'h0,        1'b1, 32'h11112222);

      // Reset while BUSY must abandon the pending write.
      req_a(32'h0000_0200, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
      got = 1'b0;
      @(posedge clk); #1;
      dreq_a.valid  = 1'b1;
      dreq_a.addr   = 32'h0000_0200;
      dreq_a.size   = MSIZE4;
      dreq_a.strobe = 4'hF;
      dreq_a.data   = 32'h12345678;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (dresp_a.addr_ok) begin
            got = 1'b1;
            break;
         end
      end
      chk("abandon_accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      dreq_a.valid = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("abandon_addr_ok", 32'(dresp_a.addr_ok), 32'd0);
      chk("abandon_data_ok", 32'(dresp_a.data_ok), 32'd0);
      chk("abandon_data",    dresp_a.data,         32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abandon_no_data_ok", 32'(dresp_a.data_ok), 32'd0);
      end
      resetn = 1'b1;
      req_a(32'h0000_0200, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D);

      // Randomised byte-strobed traffic against a word model.
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         req_a(32'h0000_0800 + 32'(i * 4), 4'hF, mdl[i], 1'b0, 32'h0);
      end
      for (int i = 0; i < 24; i++) begin
         idx  = int'($urandom_range(0, 15));
         strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         wd   = $urandom;
         req_a(32'h0000_0800 + 32'(idx * 4) + 32'($urandom_range(0, 3)), strb, wd, 1'b1, mdl[idx]);
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
         end
      end

      // LATENCY=1 with valid held high: one accept every other cycle.
      b_addr = '{32'h4, 32'h4, 32'h5, 32'h4};
      b_strb = '{4'hF, 4'h0, 4'b0010, 4'h0};
      b_data = '{32'h55AA55AA, 32'h0, 32'h0000CC00, 32'h0};
      b_chk  = '{1'b0, 1'b1, 1'b1, 1'b1};
      b_exp  = '{32'h0, 32'h55AA55AA, 32'h55AA55AA, 32'h55AACCAA};
      last   = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         dreq_b.valid  = 1'b1;
         dreq_b.addr   = b_addr[i];
         dreq_b.size   = MSIZE4;
         dreq_b.strobe = b_strb[i];
         dreq_b.data   = b_data[i];
         got = 1'b0;
         for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (dresp_b.addr_ok) begin
               got = 1'b1;
               break;
            end
         end
         chk("b_accept", 32'(got), 32'd1);
         if (got) begin
            q_b.push_back('{b_chk[i], b_exp[i], cyc});
            if (i > 0) begin
               gap = cyc - last;
               chk("b_accept_gap", 32'(gap),
                   (gap >= LAT_B + 1 && gap <= LAT_B + 1 + GAP_SLACK) ? 32'(gap) : 32'(LAT_B + 1));
            end
            last = cyc;
         end
         @(posedge clk); #1;
      end
      dreq_b.valid = 1'b0;

      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (q_a.size() == 0 && q_b.size() == 0) break;
      end
      repeat (4) @(negedge clk);
      chk("queues_drained", 32'(q_a.size() + q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
